// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic PAR_SENSE_EVEN = 1'b0;
  localparam logic PAR_SENSE_ODD  = 1'b1;

  // Data narrower than 8 bits is zero-extended by the caller; the zeros do not change the XOR.
  function automatic logic parity_of(input logic [7:0] data, input logic sense);
    return (^data) ^ sense;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Per-bit cycle counter: counts 0..DELAY_COUNTS-1 while enabled, held at 0 otherwise.
module tx_bit_timer #(
  parameter int DELAY_COUNTS = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int CW = $clog2(DELAY_COUNTS);
  localparam logic [CW-1:0] LAST = CW'(DELAY_COUNTS - 1);
  localparam logic [CW-1:0] PRE  = CW'(DELAY_COUNTS - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // bit_pre_end lets the caller register outputs that must coincide with bit_end.
  assign bit_end     = enable && (count == LAST);
  assign bit_pre_end = enable && (count == PRE);

endmodule

// File: rtl/uart_tx_serializer.sv
// RS-232 transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DELAY_COUNTS = 11,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 tx
);

  if (DELAY_COUNTS < 2) begin : g_bad_delay
    $error("uart_tx_serializer: DELAY_COUNTS must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_tx_serializer: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic SENSE = (PARITY_ODD != 0) ? PAR_SENSE_ODD : PAR_SENSE_EVEN;

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 parity;
  logic                 bit_end;
  logic                 bit_pre_end;
  logic                 last_stop;

  tx_bit_timer #(
    .DELAY_COUNTS(DELAY_COUNTS)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .enable     (state != IDLE),
    .bit_end    (bit_end),
    .bit_pre_end(bit_pre_end)
  );

  assign tx_ready  = (state == IDLE);
  assign last_stop = (stop_idx == LAST_STOP);

  // tx is loaded with the level of the state being entered, so it changes together with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      parity   <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= (state == STOP) && bit_pre_end && last_stop;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_valid) begin
            state    <= START;
            shreg    <= tx_data;
            parity   <= parity_of(8'(tx_data), SENSE);
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_idx == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= parity;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            if (last_stop) begin
              state <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
